// File: rtl/alu_result_writer.sv
// Streams a captured 5x5 int8 result matrix into memory one element per write/ack handshake.
// Optional status byte after the matrix: define WRITER_STATUS_WORD_EN.
module alu_result_writer #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned N_ELEM = 25,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ELEM_W*N_ELEM-1:0]   C_flat,
    input  logic                       ovf_in,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [ELEM_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf_out
);

    localparam int unsigned CNT_W = $clog2(N_ELEM + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ELEM - 1);

`ifdef WRITER_STATUS_WORD_EN
    typedef enum logic [1:0] {StIdle, StWrite, StStatus, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;
`endif

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ELEM_W*N_ELEM-1:0]  data_q, data_d;
    logic                      ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    // The capture register shifts down on every accept, so element cnt is always in the low byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = C_flat;
                    ovf_d   = ovf_in;
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                    data_d = data_q >> ELEM_W;
                    if (cnt_q == LAST_CNT) begin
`ifdef WRITER_STATUS_WORD_EN
                        state_d = StStatus;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef WRITER_STATUS_WORD_EN
            StStatus: begin
                if (mem_ack) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_we    = (state_q == StWrite);
        mem_addr  = addr_q;
        mem_wdata = data_q[ELEM_W-1:0];
`ifdef WRITER_STATUS_WORD_EN
        if (state_q == StStatus) begin
            mem_we    = 1'b1;
            mem_wdata = {{(ELEM_W-1){1'b0}}, ovf_q};
        end
`endif
        busy    = mem_we;
        done    = (state_q == StDone);
        // Hidden while a write is in flight: the register already holds the new capture.
        ovf_out = ovf_q & ~busy;
    end

endmodule

// File: tb/tb_alu_result_writer.sv
// Bench for alu_result_writer: table of matrix transfers plus reset, abort and ignored-start cases.
`timescale 1ns/1ps
module tb_alu_result_writer;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int ADDR_W = 8;
`ifdef WRITER_STATUS_WORD_EN
    localparam int N_WR = N_ELEM + 1;
`else
    localparam int N_WR = N_ELEM;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic                     ovf_in = 1'b0;
    logic                     mem_ack = 1'b0;
    logic [ADDR_W-1:0]        base_addr = '0;
    logic [ELEM_W*N_ELEM-1:0] c_flat = '0;
    logic                     mem_we, busy, done, ovf_out;
    logic [ADDR_W-1:0]        mem_addr;
    logic [ELEM_W-1:0]        mem_wdata;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_idx = 0;
    int stall_elem = -1;
    int stall_left = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0] base;
        logic       ovf;
        logic [7:0] mul;
        logic [7:0] add;
        int         s_elem;
        int         s_n;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    alu_result_writer #(
        .ELEM_W(ELEM_W),
        .N_ELEM(N_ELEM),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .C_flat   (c_flat),
        .ovf_in   (ovf_in),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .ovf_out  (ovf_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: decides ack for the coming edge and scores every accepted write.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() == 0) begin
                mem_ack = 1'b1;
            end else if (wr_idx == stall_elem && stall_left > 0) begin
                mem_ack = 1'b0;
                stall_left--;
                check("held_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                check("held_data", 32'(mem_wdata), 32'(exp_q[0].data));
            end else begin
                wr_t w;
                mem_ack = 1'b1;
                w = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.addr));
                check("wr_data", 32'(mem_wdata), 32'(w.data));
                wr_idx++;
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_txn(input logic [7:0] base, input logic ovf, input logic [7:0] mul,
                             input logic [7:0] add, input int s_elem, input int s_n);
        wr_t w;
        logic [7:0] e;
        @(negedge clk); #1;
        for (int i = 0; i < N_ELEM; i++) begin
            e = 8'(i) * mul + add;
            c_flat[i*ELEM_W +: ELEM_W] = e;
            w.addr = base + 8'(i);
            w.data = e;
            exp_q.push_back(w);
        end
`ifdef WRITER_STATUS_WORD_EN
        w.addr = base + 8'(N_ELEM);
        w.data = {7'b0, ovf};
        exp_q.push_back(w);
`endif
        base_addr  = base;
        ovf_in     = ovf;
        wr_idx     = 0;
        stall_elem = s_elem;
        stall_left = s_n;
        start      = 1'b1;
        @(negedge clk); #1;
        start     = 1'b0;
        c_flat    = ~c_flat;
        ovf_in    = ~ovf;
        base_addr = ~base;
    endtask

    task automatic finish_txn(input string name, input int exp_cyc, input logic exp_ovf);
        int cyc = 2;
        int d0 = done_cnt;
        while (!done && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
        end
        check({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({name, "_ovf_out"}, 32'(ovf_out), 32'(exp_ovf));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check({name, "_all_written"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        check({name, "_done_single"}, 32'(done), 32'd0);
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_ovf_held"}, 32'(ovf_out), 32'(exp_ovf));
    endtask

    task automatic wait_wr(input int n);
        int guard = 0;
        while (wr_idx < n && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        check("wait_wr_reached", 32'(wr_idx >= n), 32'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_we"}, 32'(mem_we), 32'd0);
        check({name, "_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_ovf"}, 32'(ovf_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{base: 8'h10, ovf: 1'b0, mul: 8'd1, add: 8'h00, s_elem: -1, s_n: 0};
        vecs[1] = '{base: 8'h10, ovf: 1'b0, mul: 8'd1, add: 8'h00, s_elem: 7,  s_n: 3};
        vecs[2] = '{base: 8'hF0, ovf: 1'b1, mul: 8'd1, add: 8'h80, s_elem: -1, s_n: 0};
        vecs[3] = '{base: 8'hFF, ovf: 1'b0, mul: 8'd7, add: 8'h03, s_elem: 24, s_n: 2};
        vecs[4] = '{base: 8'h10, ovf: 1'b1, mul: 8'd1, add: 8'h00, s_elem: 0,  s_n: 1};

        // Reset asserted from time zero
        #2;
        check_idle_outputs("reset");
        repeat (3) begin
            @(negedge clk); #1;
            check("reset_hold_we", 32'(mem_we), 32'd0);
        end
        rst_n = 1'b1;

        // Abort mid-write with an asynchronous reset
        d0 = done_cnt;
        start_txn(8'h10, 1'b1, 8'd3, 8'd5, -1, 0);
        wait_wr(12);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) begin
            @(negedge clk); #1;
            check("abort_hold_we", 32'(mem_we), 32'd0);
            check("abort_hold_done", 32'(done), 32'd0);
        end
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            start_txn(vecs[v].base, vecs[v].ovf, vecs[v].mul, vecs[v].add,
                      vecs[v].s_elem, vecs[v].s_n);
            finish_txn($sformatf("vec%0d", v), N_WR + 2 + vecs[v].s_n, vecs[v].ovf);
        end

        // Starts while busy, on the final ack, and during done are all ignored
        d0 = done_cnt;
        start_txn(8'h40, 1'b0, 8'd5, 8'd1, -1, 0);
        wait_wr(5);
        c_flat    = {N_ELEM{8'hA5}};
        base_addr = 8'h99;
        ovf_in    = 1'b1;
        start     = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_wr(N_WR);
        start = 1'b1;
        @(negedge clk); #1;
        check("ign_done_pulse", 32'(done), 32'd1);
        @(negedge clk); #1;
        start = 1'b0;
        check("ign_not_restarted", 32'(busy), 32'd0);
        check("ign_no_we", 32'(mem_we), 32'd0);
        check("ign_ovf_out", 32'(ovf_out), 32'd0);
        check("ign_all_written", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("ign_single_done", 32'(done_cnt - d0), 32'd1);
        check("ign_still_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
